// File: rtl/core_pkg.sv
// Shared core definitions: architectural register geometry and common datapath types.
package core_pkg;

   localparam int unsigned REG_WIDTH = 64;
   localparam int unsigned NUM_REGS  = 32;

   typedef logic [4:0]  reg_idx_t;
   typedef logic [63:0] word_t;

   localparam reg_idx_t XZR_IDX = 5'd31;

endpackage

// File: rtl/regfile_32x64_if.sv
// ID/WB-side bus of the register file: one write port, two combinational read ports.
interface regfile_32x64_if
   import core_pkg::*;
#(
   parameter int unsigned WIDTH = REG_WIDTH
);

   logic             reg_write;
   reg_idx_t         wr_addr;
   logic [WIDTH-1:0] wr_data;
   reg_idx_t         rd_addr_a;
   reg_idx_t         rd_addr_b;
   logic [WIDTH-1:0] rd_data_a;
   logic [WIDTH-1:0] rd_data_b;

   modport master (
      output reg_write, wr_addr, wr_data, rd_addr_a, rd_addr_b,
      input  rd_data_a, rd_data_b
   );

   modport slave (
      input  reg_write, wr_addr, wr_data, rd_addr_a, rd_addr_b,
      output rd_data_a, rd_data_b
   );

endinterface

// File: rtl/dec_5to32.sv
// One-hot write-enable decoder for the register file; the XZR line never fires.
module dec_5to32
   import core_pkg::*;
(
   input  logic                en,
   input  reg_idx_t            addr,
   output logic [NUM_REGS-1:0] lines
);

   always_comb begin
      lines = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         lines[i] = en && (addr == reg_idx_t'(i));
      end
      lines[XZR_IDX] = 1'b0;
   end

endmodule

// File: rtl/reg_en.sv
// Core standard write-enabled register with asynchronous active-high clear.
module reg_en #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/regfile_32x64.sv
// AArch64 X0..X30 + XZR register file: 31 stored words, two read ports with WB bypass.
module regfile_32x64
   import core_pkg::*;
#(
   parameter int unsigned WIDTH  = REG_WIDTH,
   parameter int unsigned NREGS  = NUM_REGS,
   parameter int unsigned ZR_IDX = 32'(XZR_IDX)
) (
   input  logic                  clk,
   input  logic                  reset,
   regfile_32x64_if.slave        bus
);

   localparam reg_idx_t ZR = reg_idx_t'(ZR_IDX);

   logic [NUM_REGS-1:0]         wr_lines;
   logic [NREGS-1:0][WIDTH-1:0] words;
   logic [WIDTH-1:0]            mux_a;
   logic [WIDTH-1:0]            mux_b;
   logic                        bypass_a;
   logic                        bypass_b;
   logic                        unused_zr_line;

   dec_5to32 u_dec (
      .en    (bus.reg_write),
      .addr  (bus.wr_addr),
      .lines (wr_lines)
   );

   assign unused_zr_line = wr_lines[ZR_IDX];

   // XZR has no flop: its mux input is a constant zero.
   for (genvar i = 0; i < NREGS; i++) begin : g_word
      if (i == ZR_IDX) begin : g_zr
         assign words[i] = '0;
      end else begin : g_reg
         reg_en #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (wr_lines[i]),
            .d     (bus.wr_data),
            .q     (words[i])
         );
      end
   end

   always_comb begin
      mux_a    = words[bus.rd_addr_a];
      mux_b    = words[bus.rd_addr_b];
      bypass_a = bus.reg_write && (bus.wr_addr == bus.rd_addr_a) && (bus.wr_addr != ZR) && !reset;
      bypass_b = bus.reg_write && (bus.wr_addr == bus.rd_addr_b) && (bus.wr_addr != ZR) && !reset;
   end

   always_comb begin
      if (bus.rd_addr_a == ZR) begin
         bus.rd_data_a = '0;
      end else if (bypass_a) begin
         bus.rd_data_a = bus.wr_data;
      end else begin
         bus.rd_data_a = mux_a;
      end
   end

   always_comb begin
      if (bus.rd_addr_b == ZR) begin
         bus.rd_data_b = '0;
      end else if (bypass_b) begin
         bus.rd_data_b = bus.wr_data;
      end else begin
         bus.rd_data_b = mux_b;
      end
   end

endmodule
